// File: rtl/conv1_dense_pkg.sv
// conv1_dense_pkg
//   Shared types and constants for the conv1/layer1 dense datapath scheduler.
//   - sched_state_t : scheduler FSM states
//   - COL_NUM       : 16-bit features per 400-bit feature row
//   - IC_NUM        : input channels accumulated per output pixel
//   - FEA_W / ROW_W : feature and row widths
//   - COL_W / IC_W / PIX_W : widths of the column, channel and pixel counters
package conv1_dense_pkg;

  localparam int COL_NUM = 25;
  localparam int IC_NUM  = 3;
  localparam int FEA_W   = 16;
  localparam int ROW_W   = 400;

  localparam int COL_W   = 5;
  localparam int IC_W    = 2;
  localparam int PIX_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_ROW = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_MX  = 3'd4,
    S_DRAIN    = 3'd5,
    S_DONE     = 3'd6
  } sched_state_t;

endpackage

// File: rtl/conv1_sched_cnt.sv
// conv1_sched_cnt
//   Wrapping up-counter: counts 0..max_i, then returns to 0.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     en_i      : advance by one (wraps at max_i)
//     clr_i     : force to 0 (wins over en_i)
//     max_i     : last value before wrapping
//     cnt_o     : current count
//     wrap_o    : en_i while the count sits at max_i (this advance wraps)
module conv1_sched_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == max_i) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i & (cnt_q == max_i);

endmodule

// File: rtl/conv1_dense_sched.sv
// conv1_dense_sched
//   Tile scheduler for the conv1/layer1 dense datapath. Accepts one tile
//   command (pixel count + path select) and sequences row fetches, column
//   slicing, input-channel loop markers, backpressure halting and the final
//   pipeline drain.
//
//   Handshake: start is a pulse accepted only in IDLE. mxres_v is a level
//   held by the adder tree until consumed; it is consumed in WAIT_MX on the
//   first cycle with halt=0, which is the same cycle data_v_4conv1 is high.
//   fetch_req and data_v_4conv1 are single-cycle strobes, never high while
//   halt=1.
//
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     start           : tile start pulse
//     mx_en           : 1 = matrix path, 0 = shortcut path (sampled at start)
//     pix_total       : output pixels in the tile (sampled at start)
//     bp_stall        : downstream FIFO full
//     mxres_v         : adder-tree result valid
//     halt            : global freeze (bp_stall & busy)
//     fetch_req       : request the next feature row
//     col_sel         : feature slice index within the row
//     ic_idx          : current input channel
//     sel_mx          : multiplier fed from the adder tree
//     data_v_4conv1   : element valid into the parallel multiplier
//     acc_first       : element is input channel 0
//     acc_last        : element is input channel IC_NUM-1
//     busy            : tile in progress
//     done            : one-cycle end-of-tile pulse
//     stall_cnt       : halted cycles in the current/last tile
//
//   Build option: CONV1_SCHED_PERF_EN enables the stall_cnt counter;
//   without it stall_cnt is tied to 0.
module conv1_dense_sched
  import conv1_dense_pkg::*;
#(
  parameter int COL_NUM   = conv1_dense_pkg::COL_NUM,
  parameter int IC_NUM    = conv1_dense_pkg::IC_NUM,
  parameter int FETCH_LAT = 2,
  parameter int DRAIN_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mx_en,
  input  logic [15:0] pix_total,
  input  logic        bp_stall,
  input  logic        mxres_v,
  output logic        halt,
  output logic        fetch_req,
  output logic [4:0]  col_sel,
  output logic [1:0]  ic_idx,
  output logic        sel_mx,
  output logic        data_v_4conv1,
  output logic        acc_first,
  output logic        acc_last,
  output logic        busy,
  output logic        done,
  output logic [31:0] stall_cnt
);

  localparam int TMR_W = 16;

  sched_state_t       state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               mx_en_q;
  logic [PIX_W-1:0]   pix_total_q;

  logic               start_acc;
  logic               issue_fire;
  logic [COL_W-1:0]   col_q;
  logic [IC_W-1:0]    ic_q;
  logic               col_wrap;
  logic               ic_wrap;
  logic               pix_wrap;
  // Only the wrap of the pixel counter matters; its value is not consumed.
  logic [PIX_W-1:0]   unused_pix_q;

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign halt       = bp_stall & busy;
  // An element leaves on every unhalted ISSUE cycle, or in WAIT_MX when the
  // adder-tree result is present.
  assign issue_fire = ~halt & ((state_q == S_ISSUE) |
                               ((state_q == S_WAIT_MX) & mxres_v));

  conv1_sched_cnt #(.W(COL_W)) u_col_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (issue_fire),
    .clr_i  (start_acc),
    .max_i  (COL_W'(COL_NUM - 1)),
    .cnt_o  (col_q),
    .wrap_o (col_wrap)
  );

  conv1_sched_cnt #(.W(IC_W)) u_ic_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (issue_fire),
    .clr_i  (start_acc),
    .max_i  (IC_W'(IC_NUM - 1)),
    .cnt_o  (ic_q),
    .wrap_o (ic_wrap)
  );

  // Max is the last pixel of the tile, so its wrap marks the final element.
  conv1_sched_cnt #(.W(PIX_W)) u_pix_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ic_wrap),
    .clr_i  (start_acc),
    .max_i  (pix_total_q - 16'd1),
    .cnt_o  (unused_pix_q),
    .wrap_o (pix_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      mx_en_q     <= 1'b0;
      pix_total_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (start_acc) begin
        mx_en_q     <= mx_en;
        pix_total_q <= pix_total;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (pix_total == 16'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!halt) begin
          timer_d = '0;
          if (mx_en_q) begin
            state_d = S_WAIT_MX;
          end else if (FETCH_LAT == 1) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_WAIT_ROW;
          end
        end
      end
      S_WAIT_ROW: begin
        if (!halt) begin
          if (timer_q == TMR_W'(FETCH_LAT - 2)) begin
            state_d = S_ISSUE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (!halt) begin
          if (pix_wrap) begin
            state_d = S_DRAIN;
            timer_d = '0;
          end else if (col_wrap) begin
            state_d = S_FETCH;
          end
        end
      end
      S_WAIT_MX: begin
        if (issue_fire) begin
          state_d = pix_wrap ? S_DRAIN : S_FETCH;
          timer_d = '0;
        end
      end
      S_DRAIN: begin
        if (!halt) begin
          if (timer_q == TMR_W'(DRAIN_CYC - 1)) begin
            state_d = S_DONE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fetch_req     = ~halt & (state_q == S_FETCH);
  assign sel_mx        = (state_q == S_WAIT_MX);
  assign data_v_4conv1 = issue_fire;
  assign col_sel       = col_q;
  assign ic_idx        = ic_q;
  assign acc_first     = issue_fire & (ic_q == '0);
  assign acc_last      = issue_fire & (ic_q == IC_W'(IC_NUM - 1));
  assign done          = (state_q == S_DONE);

`ifdef CONV1_SCHED_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (start_acc) begin
      stall_cnt_q <= '0;
    end else if (halt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv1_dense_sched.sv
// tb_conv1_dense_sched
//   Bench for conv1_dense_sched. A reference model plans each tile in
//   "unhalted time" (element/fetch timestamps from plain arithmetic), then
//   maps it onto real cycles using the bp_stall pattern, producing one
//   expected output vector per cycle in exp_q.
module tb_conv1_dense_sched;

  localparam int FL   = 2;
  localparam int DR   = 8;
  localparam int CN   = 25;
  localparam int ICN  = 3;
  localparam int MAXU = 1024;
  localparam int MAXC = 2048;

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mx_en;
  logic [15:0] pix_total;
  logic        bp_stall;
  logic        mxres_v;
  logic        halt;
  logic        fetch_req;
  logic [4:0]  col_sel;
  logic [1:0]  ic_idx;
  logic        sel_mx;
  logic        data_v_4conv1;
  logic        acc_first;
  logic        acc_last;
  logic        busy;
  logic        done;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  conv1_dense_sched #(
    .COL_NUM   (CN),
    .IC_NUM    (ICN),
    .FETCH_LAT (FL),
    .DRAIN_CYC (DR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mx_en         (mx_en),
    .pix_total     (pix_total),
    .bp_stall      (bp_stall),
    .mxres_v       (mxres_v),
    .halt          (halt),
    .fetch_req     (fetch_req),
    .col_sel       (col_sel),
    .ic_idx        (ic_idx),
    .sel_mx        (sel_mx),
    .data_v_4conv1 (data_v_4conv1),
    .acc_first     (acc_first),
    .acc_last      (acc_last),
    .busy          (busy),
    .done          (done),
    .stall_cnt     (stall_cnt)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [14:0] exp_q[$];

  int velem [MAXU];
  bit vfetch[MAXU];
  bit vselmx[MAXU];
  bit vmx   [MAXU];
  bit stall_a[MAXC];
  bit mx_a   [MAXC];
  int d_arr  [256];
  int ncyc;
  int exp_stalls;

  // per-tile observations
  int n_fetch, n_valid, n_last, done_cyc;
  int first_valid_cyc, first_col, last_col, last_ic, last_valid_cyc, resume_col;
  int fetch_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] pack(input logic b, input logic d, input logic h,
                                       input logic f, input logic v, input logic s,
                                       input logic af, input logic al,
                                       input logic [4:0] col, input logic [1:0] ic);
    return {b, d, h, f, v, s, af, al, col, ic};
  endfunction

  // reference model
  task automatic build_model(input int n, input bit mx);
    int u_last, t_done, u, e, f;
    bit b, h, v;
    for (int i = 0; i < MAXU; i++) begin
      velem[i] = -1; vfetch[i] = 0; vselmx[i] = 0; vmx[i] = 0;
    end
    u_last = 0;
    if (!mx) begin
      for (int k = 0; k < n * ICN; k++) begin
        u = 1 + FL + (k / CN) * (FL + CN) + (k % CN);
        velem[u] = k;
        if (k % CN == 0) vfetch[u - FL] = 1;
        u_last = u;
      end
    end else begin
      f = 1;
      for (int k = 0; k < n * ICN; k++) begin
        vfetch[f] = 1;
        for (int t = f + 1; t <= f + d_arr[k]; t++) vselmx[t] = 1;
        vmx[f + d_arr[k]]   = 1;
        velem[f + d_arr[k]] = k;
        u_last = f + d_arr[k];
        f = u_last + 1;
      end
    end
    t_done = (n == 0) ? 1 : u_last + 1 + DR;
    exp_q.delete();
    exp_stalls = 0;
    ncyc = MAXC;
    u = 0;
    for (int c = 0; c < MAXC; c++) begin
      b = (u >= 1) && (u < t_done);
      h = b && stall_a[c];
      e = velem[u];
      v = !h && (e >= 0);
      exp_q.push_back(pack(b, u == t_done, h, !h && vfetch[u], v, vselmx[u],
                           v && (e % ICN == 0), v && (e % ICN == ICN - 1),
                           v ? 5'(e % CN) : 5'd0, v ? 2'(e % ICN) : 2'd0));
      mx_a[c] = vmx[u];
      if (h) exp_stalls++;
      if (u == t_done) begin
        ncyc = c + 1;
        break;
      end
      if (!h) u++;
    end
  endtask

  task automatic clear_stall();
    for (int i = 0; i < MAXC; i++) stall_a[i] = 0;
  endtask

  task automatic stall_window(input int a, input int b);
    for (int i = a; i <= b; i++) stall_a[i] = 1;
  endtask

  // driver: runs one tile cycle by cycle; abort_at >= 0 pulses rst there
  task automatic run_tile(input int n, input bit mx, input int abort_at);
    logic [14:0] obs, expv;
    bit saw_halt;
    build_model(n, mx);
    n_fetch = 0; n_valid = 0; n_last = 0; done_cyc = -1;
    first_valid_cyc = -1; first_col = -1; last_col = -1; last_ic = -1;
    last_valid_cyc = -1; resume_col = -1; saw_halt = 0;
    fetch_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      start     = (c == 0);
      mx_en     = mx;
      pix_total = 16'(n);
      bp_stall  = stall_a[c];
      mxres_v   = mx_a[c];
      rst       = (c == abort_at);
      @(negedge clk);
      obs = pack(busy, done, halt, fetch_req, data_v_4conv1, sel_mx, acc_first, acc_last,
                 data_v_4conv1 ? col_sel : 5'd0, data_v_4conv1 ? ic_idx : 2'd0);
      expv = exp_q.pop_front();
      check_eq($sformatf("cyc%0d_n%0d_mx%0d", c, n, mx), {17'd0, obs}, {17'd0, expv});
      if (fetch_req) begin
        n_fetch++;
        fetch_cyc.push_back(c);
      end
      if (halt) saw_halt = 1;
      if (data_v_4conv1) begin
        if (n_valid == 0) begin
          first_valid_cyc = c;
          first_col = int'(col_sel);
        end
        if (saw_halt && resume_col < 0) resume_col = int'(col_sel);
        n_valid++;
        last_col = int'(col_sel);
        last_ic = int'(ic_idx);
        last_valid_cyc = c;
      end
      if (acc_last) n_last++;
      if (done) done_cyc = c;
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        rst = 0;
        break;
      end
    end
    start = 0; bp_stall = 0; mxres_v = 0;
    if (abort_at < 0) begin
`ifdef CONV1_SCHED_PERF_EN
      check_eq("stall_cnt", stall_cnt, 32'(exp_stalls));
`else
      check_eq("stall_cnt", stall_cnt, 32'd0);
`endif
    end
  endtask

  initial begin
    int n, busy_or_done;
    bit mx;
    rst = 1; start = 0; mx_en = 0; pix_total = 0; bp_stall = 0; mxres_v = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", {17'd0, pack(busy, done, halt, fetch_req, data_v_4conv1, sel_mx,
                                        acc_first, acc_last, col_sel, ic_idx)}, 32'd0);
    check_eq("reset_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;

    // shortcut, three full rows
    clear_stall();
    run_tile(25, 0, -1);
    check_eq("A_fetch_n", n_fetch, 3);
    check_eq("A_fetch1", (fetch_cyc.size() > 1) ? fetch_cyc[1] : -1, 28);
    check_eq("A_fetch2", (fetch_cyc.size() > 2) ? fetch_cyc[2] : -1, 55);
    check_eq("A_first_valid", first_valid_cyc, 3);
    check_eq("A_valid_n", n_valid, 75);
    check_eq("A_last_n", n_last, 25);
    check_eq("A_done", done_cyc, 90);

    // shortcut, partial last row
    run_tile(10, 0, -1);
    check_eq("B_fetch_n", n_fetch, 2);
    check_eq("B_valid_n", n_valid, 30);
    check_eq("B_last_col", last_col, 4);
    check_eq("B_last_ic", last_ic, 2);
    check_eq("B_done_gap", done_cyc - last_valid_cyc, 9);

    // next tile restarts at column 0
    run_tile(3, 0, -1);
    check_eq("C_first_col", first_col, 0);
    check_eq("C_valid_n", n_valid, 9);

    // matrix path, response 5 cycles after each fetch
    for (int i = 0; i < 256; i++) d_arr[i] = 5;
    run_tile(2, 1, -1);
    check_eq("D_fetch_n", n_fetch, 6);
    check_eq("D_valid_n", n_valid, 6);

    // 10-cycle stall after column 12 has issued
    stall_window(16, 25);
    run_tile(25, 0, -1);
    check_eq("E_resume_col", resume_col, 13);
    check_eq("E_done", done_cyc, 100);
    check_eq("E_valid_n", n_valid, 75);
`ifdef CONV1_SCHED_PERF_EN
    check_eq("E_stall_cnt", stall_cnt, 32'd10);
`else
    check_eq("E_stall_cnt", stall_cnt, 32'd0);
`endif
    clear_stall();

    // empty tile
    run_tile(0, 0, -1);
    check_eq("F_done", done_cyc, 1);
    check_eq("F_fetch_n", n_fetch, 0);
    check_eq("F_valid_n", n_valid, 0);

    // matrix result arriving while halted
    for (int i = 0; i < 256; i++) d_arr[i] = 2;
    stall_window(3, 5);
    run_tile(1, 1, -1);
    check_eq("G_first_valid", first_valid_cyc, 6);
    check_eq("G_valid_n", n_valid, 3);
    clear_stall();

    // reset mid-tile
    run_tile(25, 0, 20);
    bp_stall = 1;
    @(negedge clk);
    check_eq("H_outs_after_rst", {17'd0, pack(busy, done, halt, fetch_req, data_v_4conv1, sel_mx,
                                              acc_first, acc_last, col_sel, ic_idx)}, 32'd0);
    check_eq("H_stall_cnt", stall_cnt, 32'd0);
    busy_or_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || done) busy_or_done++;
    end
    check_eq("H_no_done", busy_or_done, 0);
    @(posedge clk);
    #1;
    bp_stall = 0;
    run_tile(25, 0, -1);
    check_eq("H_fetch_n", n_fetch, 3);
    check_eq("H_done", done_cyc, 90);

    // randomized tiles with random stalls and response delays
    for (int t = 0; t < 8; t++) begin
      n  = int'($urandom_range(1, 30));
      mx = bit'($urandom_range(0, 1));
      for (int i = 0; i < 256; i++) d_arr[i] = int'($urandom_range(1, 6));
      for (int i = 0; i < MAXC; i++) stall_a[i] = ($urandom_range(0, 5) == 0);
      run_tile(n, mx, -1);
      check_eq($sformatf("R%0d_valid_n", t), n_valid, n * ICN);
      check_eq($sformatf("R%0d_last_n", t), n_last, n);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
